// File: rtl/riscv_if_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package riscv_if_stage_pkg;

    localparam int IF_XLEN = 32;
    localparam logic [IF_XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [IF_XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013; // addi x0,x0,0

    // S_REQ: request on the bus; S_WAIT: one request outstanding;
    // S_HOLD: response parked in the skid buffer while decode stalls.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/riscv_if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
//
// Handshake: a request is transferred on a cycle where req=1 and gnt=1.
// While req=1 and gnt=0 the requester keeps addr stable. Exactly one
// response (rvalid=1 with rdata) follows each transferred request, at least
// one cycle later. rvalid cannot be back-pressured: the requester must
// accept or discard it in the cycle it is presented.
interface riscv_if_stage_if #(
    parameter int XLEN = 32
) ();
    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/riscv_if_stage_skid.sv
// One-entry {pc, instr} buffer that parks a response while decode is stalled.
module riscv_if_stage_skid #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic            full,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] instr_out
);

    // Flush wins over load so a redirect never leaves a stale entry behind.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            full <= 1'b0;
        end else if (load) begin
            full      <= 1'b1;
            pc_out    <= load_pc;
            instr_out <= load_instr;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/riscv_if_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem request outstanding
// and presents {pc, instr, valid} to decode through the IF/ID register.
module riscv_if_stage
    import riscv_if_stage_pkg::*;
#(
    parameter int              XLEN      = IF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_i,
    input  logic                     redirect_i,
    input  logic [XLEN-1:0]          redirect_pc_i,
    riscv_if_stage_if.master         imem,
    output logic                     if_valid_o,
    output logic [XLEN-1:0]          if_pc_o,
    output logic [XLEN-1:0]          if_instr_o,
    output logic [XLEN-1:0]          f_addr_o,
    output fetch_state_t             fetch_state_o
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_inflight;
    logic            drop;
    logic            ifid_free;
    logic            skid_load;
    logic            skid_pop;
    logic            skid_flush;
    logic            skid_full;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_instr;

    // Request depends only on registered state, never on rvalid.
    assign imem.req      = (state == S_REQ) && !rst;
    assign imem.addr     = pc;
    assign f_addr_o      = pc;
    assign fetch_state_o = state;
    assign ifid_free     = !if_valid_o || !stall_i;

    // Skid control: park a response when IF/ID is occupied and stalled.
    always_comb begin
        skid_flush = redirect_i;
        skid_load  = 1'b0;
        skid_pop   = 1'b0;
        if (!redirect_i) begin
            skid_load = (state == S_WAIT) && imem.rvalid && !drop && !ifid_free;
            skid_pop  = (state == S_HOLD) && skid_full && !stall_i;
        end
    end

    riscv_if_stage_skid #(.XLEN(XLEN)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .pop        (skid_pop),
        .flush      (skid_flush),
        .load_pc    (pc_inflight),
        .load_instr (imem.rdata),
        .full       (skid_full),
        .pc_out     (skid_pc),
        .instr_out  (skid_instr)
    );

    // Fetch FSM, PC, drop flag and IF/ID register; redirect beats everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            pc_inflight <= RESET_PC;
            drop        <= 1'b0;
            if_valid_o  <= 1'b0;
            if_pc_o     <= '0;
            if_instr_o  <= NOP_INSTR;
        end else if (redirect_i) begin
            pc         <= {redirect_pc_i[XLEN-1:2], 2'b00};
            if_valid_o <= 1'b0;
            if_instr_o <= NOP_INSTR;
            // A response still owed by imem must be swallowed when it lands.
            if ((state == S_REQ && imem.gnt) || (state == S_WAIT && !imem.rvalid)) begin
                drop  <= 1'b1;
                state <= S_WAIT;
            end else begin
                drop  <= 1'b0;
                state <= S_REQ;
            end
        end else begin
            // Decode takes the instruction; a load below overrides this.
            if (if_valid_o && !stall_i) begin
                if_valid_o <= 1'b0;
                if_instr_o <= NOP_INSTR;
            end
            case (state)
                S_REQ: begin
                    if (imem.gnt) begin
                        pc_inflight <= pc;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.rvalid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else if (ifid_free) begin
                            if_valid_o <= 1'b1;
                            if_pc_o    <= pc_inflight;
                            if_instr_o <= imem.rdata;
                            pc         <= pc + XLEN'(4);
                            state      <= S_REQ;
                        end else begin
                            pc    <= pc + XLEN'(4);
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (skid_pop) begin
                        if_valid_o <= 1'b1;
                        if_pc_o    <= skid_pc;
                        if_instr_o <= skid_instr;
                        state      <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_if_stage.sv
// Bench for riscv_if_stage: imem responder model, program-order scoreboard,
// directed scenarios followed by a randomized stall/redirect phase.
module tb_riscv_if_stage;
    import riscv_if_stage_pkg::*;

    localparam int           W        = IF_XLEN;
    localparam logic [W-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [W-1:0] NOP      = 32'h0000_0013;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stall = 1'b0;
    logic         redirect = 1'b0;
    logic [W-1:0] redirect_pc = '0;
    logic         if_valid;
    logic [W-1:0] if_pc;
    logic [W-1:0] if_instr;
    logic [W-1:0] f_addr;
    fetch_state_t fstate;

    riscv_if_stage_if #(.XLEN(W)) imem ();

    riscv_if_stage #(.XLEN(W), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem          (imem),
        .if_valid_o    (if_valid),
        .if_pc_o       (if_pc),
        .if_instr_o    (if_instr),
        .f_addr_o      (f_addr),
        .fetch_state_o (fstate)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int consumed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_0000;
    endfunction

    // ---------------- imem responder ----------------
    int           gnt_pct = 100;
    int           lat_min = 1;
    int           lat_max = 1;
    bit           resp_pend = 1'b0;
    logic [W-1:0] resp_addr = '0;
    int           resp_wait = 0;

    initial begin
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata  = '0;
    end

    always @(posedge clk) begin
        #1;
        imem.gnt    = (int'($urandom_range(0, 99)) < gnt_pct);
        imem.rvalid = 1'b0;
        imem.rdata  = $urandom;
        if (resp_pend) begin
            if (resp_wait <= 1) begin
                imem.rvalid = 1'b1;
                imem.rdata  = mem_word(resp_addr);
            end else begin
                resp_wait--;
            end
        end
    end

    always @(negedge clk) begin
        if (imem.rvalid) resp_pend = 1'b0;
        if (imem.req && imem.gnt) begin
            resp_pend = 1'b1;
            resp_addr = imem.addr;
            resp_wait = int'($urandom_range(lat_min, lat_max));
        end
    end

    // ---------------- scoreboard: program-order delivery ----------------
    logic [W-1:0] exp_next_pc = '0;
    logic [W-1:0] redir_addr = '0;
    logic [W-1:0] stable_addr = '0;
    logic [W-1:0] exp_q[$];
    bit           redir_pend = 1'b0;
    bit           after_redirect = 1'b0;
    bit           stable_pend = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_req", W'(imem.req), W'(0));
            exp_next_pc    = RESET_PC;
            redir_pend     = 1'b1;
            redir_addr     = RESET_PC;
            after_redirect = 1'b0;
            stable_pend    = 1'b0;
        end else begin
            if (!if_valid) check("idle_instr_nop", if_instr, NOP);
            if (after_redirect) check("flush_valid", W'(if_valid), W'(0));
            if (stable_pend) begin
                check("hold_req", W'(imem.req), W'(1));
                check("hold_addr", imem.addr, stable_addr);
            end
            if (redir_pend && imem.req) begin
                check("restart_addr", imem.addr, redir_addr);
                redir_pend = 1'b0;
            end
            if (redirect) begin
                exp_next_pc = redirect_pc & ~32'h3;
                redir_pend  = 1'b1;
                redir_addr  = exp_next_pc;
            end else if (if_valid && !stall) begin
                check("deliver_pc", if_pc, exp_next_pc);
                check("deliver_instr", if_instr, mem_word(exp_next_pc));
                exp_next_pc = exp_next_pc + 32'd4;
                consumed++;
            end
            after_redirect = redirect;
            stable_pend    = imem.req && !imem.gnt && !redirect;
            stable_addr    = imem.addr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (if_valid) begin
                ok = 1'b1;
                return;
            end
        end
        $display("timeout waiting for if_valid, fetch state %s", fstate.name());
    endtask

    task automatic wait_grant(input logic [W-1:0] want, input bit any, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (imem.req && imem.gnt && (any || imem.addr == want)) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic pulse_redirect(input logic [W-1:0] target);
        redirect = 1'b1;
        redirect_pc = target;
        step();
        redirect = 1'b0;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        bit ok;
        int rel;
        int base;

        // 1: latency-1 memory, no stall, one instruction every 2 cycles.
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset(4);
        rel = cyc;
        @(negedge clk);
        check("t1_rst_valid", W'(if_valid), W'(0));
        check("t1_rst_pc", if_pc, W'(0));
        check("t1_rst_instr", if_instr, NOP);
        check("t1_rst_faddr", f_addr, RESET_PC);
        check("t1_first_req", W'(imem.req), W'(1));
        check("t1_first_addr", imem.addr, RESET_PC);
        for (int k = 0; k < 4; k++) exp_q.push_back(RESET_PC + W'(4 * k));
        for (int k = 0; k < 4; k++) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            wait_valid(ok);
            check("t1_valid_seen", W'(ok), W'(1));
            check("t1_pc", if_pc, e);
            check("t1_instr", if_instr, mem_word(e));
            check("t1_cycle", W'(cyc - rel), W'(2 + 2 * k));
        end

        // 2: stall for 6 cycles once the first instruction shows up.
        do_reset(4);
        step();
        step();
        stall = 1'b1;
        @(negedge clk);
        check("t2_first_valid", W'(if_valid), W'(1));
        check("t2_first_pc", if_pc, 32'h0);
        for (int i = 1; i < 6; i++) begin
            step();
            @(negedge clk);
            check("t2_hold_valid", W'(if_valid), W'(1));
            check("t2_hold_pc", if_pc, 32'h0);
            if (i >= 2) check("t2_hold_no_req", W'(imem.req), W'(0));
        end
        step();
        stall = 1'b0;
        @(negedge clk);
        check("t2_release_pc0", if_pc, 32'h0);
        step();
        @(negedge clk);
        check("t2_skid_valid", W'(if_valid), W'(1));
        check("t2_skid_pc", if_pc, 32'h4);
        check("t2_skid_instr", if_instr, mem_word(32'h4));
        check("t2_next_req", W'(imem.req), W'(1));
        check("t2_next_addr", imem.addr, 32'h8);

        // 3: redirect while the fetch of pc=8 is in flight.
        lat_min = 3; lat_max = 3;
        do_reset(4);
        wait_grant(32'h8, 1'b0, ok);
        check("t3_grant8_seen", W'(ok), W'(1));
        step();
        pulse_redirect(32'h100);
        wait_valid(ok);
        check("t3_valid_seen", W'(ok), W'(1));
        check("t3_pc", if_pc, 32'h100);
        check("t3_instr", if_instr, mem_word(32'h100));

        // 4: redirect in the same cycle as the response.
        lat_min = 2; lat_max = 2;
        step();
        step();
        wait_grant('0, 1'b1, ok);
        check("t4_grant_seen", W'(ok), W'(1));
        step();
        step();
        pulse_redirect(32'h100);
        @(negedge clk);
        check("t4_req", W'(imem.req), W'(1));
        check("t4_addr", imem.addr, 32'h100);
        check("t4_valid_dropped", W'(if_valid), W'(0));
        wait_valid(ok);
        check("t4_valid_seen", W'(ok), W'(1));
        check("t4_pc", if_pc, 32'h100);

        // 5: low address bits ignored; PC wraps past the top of memory.
        lat_min = 1; lat_max = 1;
        step();
        pulse_redirect(32'h102);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (imem.req) begin
                ok = 1'b1;
                check("t5_aligned_addr", imem.addr, 32'h100);
            end
        end
        check("t5_req_seen", W'(ok), W'(1));
        step();
        pulse_redirect(32'hFFFF_FFFE);
        wait_valid(ok);
        check("t5_top_seen", W'(ok), W'(1));
        check("t5_top_pc", if_pc, 32'hFFFF_FFFC);
        wait_valid(ok);
        check("t5_wrap_seen", W'(ok), W'(1));
        check("t5_wrap_pc", if_pc, 32'h0);
        check("t5_wrap_instr", if_instr, mem_word(32'h0));

        // 6: reset during S_WAIT, stray response on the reset-release cycle.
        lat_min = 3; lat_max = 3;
        step();
        step();
        wait_grant('0, 1'b1, ok);
        check("t6_grant_seen", W'(ok), W'(1));
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t6_rel_req", W'(imem.req), W'(1));
        check("t6_rel_addr", imem.addr, RESET_PC);
        check("t6_rel_valid", W'(if_valid), W'(0));
        step();
        @(negedge clk);
        check("t6_stray_ignored", W'(if_valid), W'(0));
        wait_valid(ok);
        check("t6_valid_seen", W'(ok), W'(1));
        check("t6_first_pc", if_pc, RESET_PC);

        // Random phase: random grant delay, latency, stalls and redirects.
        gnt_pct = 70; lat_min = 1; lat_max = 3;
        do_reset(4);
        base = consumed;
        for (int i = 0; i < 600; i++) begin
            stall = (int'($urandom_range(0, 99)) < 30);
            if (int'($urandom_range(0, 99)) < 4) begin
                redirect = 1'b1;
                redirect_pc = $urandom_range(0, 32'h3FF);
            end else begin
                redirect = 1'b0;
            end
            step();
        end
        redirect = 1'b0;
        stall = 1'b0;
        repeat (20) step();
        @(negedge clk);
        check("rand_progress", W'(consumed - base >= 60), W'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
